// File: rtl/lightboard_pkg.sv
// Shared lightboard packet geometry and unpacker state encoding.
// The transmitter and the unpacker both import this so packet layout cannot diverge.
package lightboard_pkg;

    localparam int FRAME_PIXELS      = 76800;
    localparam int PIXELS_PER_PACKET = 320;
    localparam int ADDR_BYTES        = 3;
    localparam int DIBITS_PER_BYTE   = 4;
    localparam int ADDR_W            = 17;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PIXEL,
        AUDIO,
        DISCARD
    } unpack_state_t;

    // Pixel addresses wrap back to 0 past the end of the frame memory.
    function automatic logic [ADDR_W-1:0] next_pixel_addr(
        input logic [ADDR_W-1:0] addr,
        input int                frame
    );
        return (addr == ADDR_W'(frame - 1)) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/packet_pixel_unpacker_if.sv
// Dibit stream input plus pixel-memory / audio / status outputs of the unpacker.
// master drives the stream and observes results; slave is the unpacker itself.
interface packet_pixel_unpacker_if;
    import lightboard_pkg::*;

    logic              axiiv;
    logic [1:0]        axiid;
    logic              pixel_wea;
    logic [ADDR_W-1:0] pixel_waddr;
    logic [7:0]        pixel_wdata;
    logic              audio_valid;
    logic [7:0]        audio_data;
    logic              packet_done;
    logic              packet_error;

    modport master (
        output axiiv,
        output axiid,
        input  pixel_wea,
        input  pixel_waddr,
        input  pixel_wdata,
        input  audio_valid,
        input  audio_data,
        input  packet_done,
        input  packet_error
    );

    modport slave (
        input  axiiv,
        input  axiid,
        output pixel_wea,
        output pixel_waddr,
        output pixel_wdata,
        output audio_valid,
        output audio_data,
        output packet_done,
        output packet_error
    );

endinterface

// File: rtl/dibit_byte_assembler.sv
// Collects LSB-first dibits into bytes; byte_valid is combinational on the 4th dibit
// so the consumer can register the completed byte in the same cycle.
module dibit_byte_assembler
    import lightboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic [7:0] byte_data,
    output logic       byte_valid
);

    logic [1:0] dibit_cnt;
    logic [5:0] partial;

    always_ff @(posedge clk) begin
        if (rst || !axiiv) begin
            dibit_cnt <= '0;
        end else begin
            dibit_cnt <= dibit_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            partial <= '0;
        end else if (axiiv) begin
            case (dibit_cnt)
                2'd0:    partial[1:0] <= axiid;
                2'd1:    partial[3:2] <= axiid;
                2'd2:    partial[5:4] <= axiid;
                default: ;
            endcase
        end
    end

    assign byte_valid = axiiv && (dibit_cnt == 2'(DIBITS_PER_BYTE - 1));
    assign byte_data  = {axiid, partial};

endmodule

// File: rtl/packet_pixel_unpacker.sv
// Decodes dibit packets (3-byte base address, pixel payload, trailing audio) into
// registered pixel-memory writes, audio byte strobes and done/error pulses.
module packet_pixel_unpacker #(
    parameter int PIXELS_PER_PACKET = lightboard_pkg::PIXELS_PER_PACKET,
    parameter int FRAME_PIXELS      = lightboard_pkg::FRAME_PIXELS
) (
    input logic                     clk,
    input logic                     rst,
    packet_pixel_unpacker_if.slave  bus
);
    import lightboard_pkg::*;

    localparam int CNT_W = ($clog2(PIXELS_PER_PACKET) > 2) ? $clog2(PIXELS_PER_PACKET) : 2;
    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(PIXELS_PER_PACKET - 1);
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_BYTES - 1);

    unpack_state_t     state, state_n;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_n;
    logic [15:0]       addr_acc, addr_acc_n;
    logic [ADDR_W-1:0] wptr, wptr_n;
    logic              axiiv_q;

    logic [7:0]        byte_data;
    logic              byte_valid;
    logic [23:0]       base_full;
    logic              base_in_range;

    logic              wea_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [7:0]        wdata_n;
    logic              audio_valid_n;
    logic [7:0]        audio_data_n;
    logic              done_n;
    logic              error_n;

    dibit_byte_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .axiiv      (bus.axiiv),
        .axiid      (bus.axiid),
        .byte_data  (byte_data),
        .byte_valid (byte_valid)
    );

    assign base_full     = {addr_acc, byte_data};
    assign base_in_range = int'({8'd0, base_full}) < FRAME_PIXELS;

    // Packets start only on a genuine axiiv rise, so a reset mid-packet ignores its tail.
    always_ff @(posedge clk) begin
        axiiv_q <= bus.axiiv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            addr_acc         <= '0;
            wptr             <= '0;
            bus.pixel_wea    <= 1'b0;
            bus.pixel_waddr  <= '0;
            bus.pixel_wdata  <= '0;
            bus.audio_valid  <= 1'b0;
            bus.audio_data   <= '0;
            bus.packet_done  <= 1'b0;
            bus.packet_error <= 1'b0;
        end else begin
            state            <= state_n;
            byte_cnt         <= byte_cnt_n;
            addr_acc         <= addr_acc_n;
            wptr             <= wptr_n;
            bus.pixel_wea    <= wea_n;
            bus.pixel_waddr  <= waddr_n;
            bus.pixel_wdata  <= wdata_n;
            bus.audio_valid  <= audio_valid_n;
            bus.audio_data   <= audio_data_n;
            bus.packet_done  <= done_n;
            bus.packet_error <= error_n;
        end
    end

    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        addr_acc_n    = addr_acc;
        wptr_n        = wptr;
        wea_n         = 1'b0;
        waddr_n       = '0;
        wdata_n       = '0;
        audio_valid_n = 1'b0;
        audio_data_n  = '0;
        done_n        = 1'b0;
        error_n       = 1'b0;

        case (state)
            IDLE: begin
                byte_cnt_n = '0;
                if (bus.axiiv && !axiiv_q) begin
                    state_n = ADDR;
                end
            end

            ADDR: begin
                if (!bus.axiiv) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else if (byte_valid) begin
                    addr_acc_n = base_full[15:0];
                    if (byte_cnt == LAST_ADDR) begin
                        byte_cnt_n = '0;
                        if (base_in_range) begin
                            wptr_n  = base_full[ADDR_W-1:0];
                            state_n = PIXEL;
                        end else begin
                            error_n = 1'b1;
                            state_n = DISCARD;
                        end
                    end else begin
                        byte_cnt_n = byte_cnt + CNT_W'(1);
                    end
                end
            end

            PIXEL: begin
                if (!bus.axiiv) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else if (byte_valid) begin
                    wea_n   = 1'b1;
                    waddr_n = wptr;
                    wdata_n = byte_data;
                    wptr_n  = next_pixel_addr(wptr, FRAME_PIXELS);
                    if (byte_cnt == LAST_PIXEL) begin
                        byte_cnt_n = '0;
                        state_n    = AUDIO;
                    end else begin
                        byte_cnt_n = byte_cnt + CNT_W'(1);
                    end
                end
            end

            // Any partial trailing byte simply never completes here.
            AUDIO: begin
                if (!bus.axiiv) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (byte_valid) begin
                    audio_valid_n = 1'b1;
                    audio_data_n  = byte_data;
                end
            end

            DISCARD: begin
                if (!bus.axiiv) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assert property (@(posedge clk) !(bus.packet_done && bus.packet_error));
    assert property (@(posedge clk) !(bus.pixel_wea && bus.audio_valid));

endmodule

// File: doc/packet_pixel_unpacker.md
PACKET_PIXEL_UNPACKER -- requirements
Module: packet_pixel_unpacker

Interface
REQ-001 Parameter PIXELS_PER_PACKET, default 320: pixel payload bytes per packet.
REQ-002 Parameter FRAME_PIXELS, default 76800: pixel memory depth; valid addresses are 0..FRAME_PIXELS-1.
REQ-003 Port clk  input  1: the single clock; all logic on posedge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port axiiv  input  1: input dibit valid; high for the whole packet, low between packets.
REQ-006 Port axiid  input  2: input dibit.
REQ-007 Port pixel_wea  output  1: one-cycle pixel memory write strobe.
REQ-008 Port pixel_waddr  output  17: pixel memory write address.
REQ-009 Port pixel_wdata  output  8: pixel byte.
REQ-010 Port audio_valid  output  1: one-cycle audio byte strobe.
REQ-011 Port audio_data  output  8: audio byte.
REQ-012 Port packet_done  output  1: one-cycle pulse, packet accepted.
REQ-013 Port packet_error  output  1: one-cycle pulse, packet truncated or address out of range.

Function
REQ-014 Byte assembly: dibits arrive LSB-first; dibit k of a byte lands in byte[2k+1:2k], k=0..3.
REQ-015 Bytes complete only on the 4th consecutive valid dibit; the dibit counter clears whenever axiiv is low.
REQ-016 States: IDLE, ADDR, PIXEL, AUDIO, DISCARD.
REQ-017 IDLE: first cycle with axiiv high moves to ADDR and counts that dibit.
REQ-018 ADDR: 3 bytes, most significant byte first, form 24-bit base address; on the 3rd byte go to PIXEL if base < FRAME_PIXELS, else pulse packet_error and go to DISCARD.
REQ-019 PIXEL: byte n (n=0..PIXELS_PER_PACKET-1) is written with pixel_waddr = (base+n) mod FRAME_PIXELS and pixel_wea high for one cycle.
REQ-020 Write latency: pixel_wea/pixel_wdata/pixel_waddr are registered and valid the cycle after the 4th dibit of the byte.
REQ-021 After byte PIXELS_PER_PACKET-1 go to AUDIO.
REQ-022 AUDIO: every completed byte is presented on audio_data with audio_valid high for one cycle, with the same 1-cycle latency; the number of audio bytes is unbounded.
REQ-023 axiiv falling in AUDIO, or on the cycle after the last pixel dibit: pulse packet_done one cycle later; return to IDLE.
REQ-024 axiiv falling in ADDR or PIXEL: pulse packet_error one cycle later; return to IDLE; discard the partial byte; keep pixels already written.
REQ-025 DISCARD: ignore all dibits until axiiv is low, then go to IDLE; emit no strobes.
REQ-026 Any partial trailing byte (1-3 dibits) at axiiv fall is dropped silently in AUDIO.
REQ-027 packet_done and packet_error are never high in the same cycle.
REQ-028 pixel_wea and audio_valid are never high in the same cycle.

Reset
REQ-029 When rst is high at posedge: state IDLE; dibit counter, byte counter, and base address cleared.
REQ-030 All outputs are 0 during and after reset until new input arrives; reset mid-packet drops the remainder of that packet, and the next axiiv rise starts a fresh ADDR.

Structure
REQ-031 Shared package lightboard_pkg: state enum, FRAME_PIXELS, PIXELS_PER_PACKET, ADDR_BYTES=3, DIBITS_PER_BYTE=4.
REQ-032 Sub-module dibit_byte_assembler: 2-bit stream in, byte plus byte_valid out, cleared on axiiv low.
REQ-033 The transmitter and the unpacker share the package constants so packet geometry cannot diverge.

Verification
REQ-034 Base 0x000000, pixels 0..255 then 64 more, 4 audio bytes 0xA1..0xA4, axiiv falls -> 320 writes at addr 0..319 with matching data, 4 audio_valid pulses, one packet_done.
REQ-035 Base 76799 (0x012BFF), full packet -> first write at 76799, second at 0, last at 318.
REQ-036 Base 76800 (0x012C00) -> packet_error one cycle after 3rd address byte, no pixel_wea or audio_valid for the packet.
REQ-037 axiiv falls after 100 pixel bytes plus 2 dibits -> exactly 100 writes, packet_error pulse, next packet decodes correctly.
REQ-038 rst asserted at pixel byte 150 for 1 cycle -> outputs 0 thereafter; the following packet with base 0x000140 writes 320..639.
REQ-039 Byte 0xB4 sent as dibits 00,01,11,10 -> pixel_wdata 0xB4, checked one cycle after the 4th dibit.
